uart_command_decoder: RTL and testbench

Front-end parser between the UART receiver and the memory-management processor. Collects a five-byte host frame (opcode, start address, end address), validates it and presents a stable command/address triple to the processor over a valid/ready handshake. Malformed frames, inter-byte stalls and inverted address ranges are rejected with a coded error pulse. While a command is pending, no further UART bytes are consumed.

---
 rtl/uart_command_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_uart_command_decoder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_command_decoder.sv
// uart_command_decoder
// Collects a five-byte host frame from the UART receiver (opcode, start
// address, end address, addresses big-endian). It validates the frame and
// offers the command/address triple to the memory-management processor over
// a valid/ready handshake. Rejected frames produce a one-cycle frame_error
// pulse, and err_code keeps the reason for the most recent rejection.

module uart_command_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    output logic        rx_ack,
    output logic [7:0]  command,
    output logic [15:0] start_address,
    output logic [15:0] end_address,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        frame_error,
    output logic [1:0]  err_code
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_RANGE   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SA_HI,
        ST_SA_LO,
        ST_EA_HI,
        ST_EA_LO,
        ST_CHECK,
        ST_PRESENT
    } state_e;

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  timeoutCnt_q, timeoutCnt_d;
    logic [7:0]        opcodeShadow_q, opcodeShadow_d;
    logic [15:0]       startShadow_q, startShadow_d;
    logic [15:0]       endShadow_q, endShadow_d;
    logic [7:0]        command_q, command_d;
    logic [15:0]       startAddr_q, startAddr_d;
    logic [15:0]       endAddr_q, endAddr_d;
    logic              cmdValid_q, cmdValid_d;
    logic              rxAck_q, rxAck_d;
    logic              frameError_q, frameError_d;
    logic [1:0]        errCode_q, errCode_d;

    logic              isReceive;
    logic              inFrame;
    logic              accept;
    logic              timeoutHit;

    // Classify the current state and decide whether a byte is consumed this cycle.
    // The armed flag makes a level-held rx_done count as a single byte.
    always_comb begin
        isReceive  = (state_q == ST_IDLE)  || (state_q == ST_SA_HI) ||
                     (state_q == ST_SA_LO) || (state_q == ST_EA_HI) ||
                     (state_q == ST_EA_LO);
        inFrame    = isReceive && (state_q != ST_IDLE);
        accept     = rx_done && armed_q && isReceive;
        timeoutHit = inFrame && !accept && (timeoutCnt_q == TIMEOUT_LIMIT);
    end

    // Next-state and output logic. A timeout overrides the per-state behaviour
    // and aborts the partial frame back to IDLE.
    always_comb begin
        state_d        = state_q;
        armed_d        = armed_q;
        timeoutCnt_d   = timeoutCnt_q;
        opcodeShadow_d = opcodeShadow_q;
        startShadow_d  = startShadow_q;
        endShadow_d    = endShadow_q;
        command_d      = command_q;
        startAddr_d    = startAddr_q;
        endAddr_d      = endAddr_q;
        cmdValid_d     = cmdValid_q;
        rxAck_d        = accept;
        frameError_d   = 1'b0;
        errCode_d      = errCode_q;

        if (accept) begin
            armed_d = 1'b0;
        end else if (!rx_done) begin
            armed_d = 1'b1;
        end

        if (!inFrame || accept || timeoutHit) begin
            timeoutCnt_d = '0;
        end else begin
            timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
        end

        if (timeoutHit) begin
            state_d        = ST_IDLE;
            errCode_d      = ERR_TIMEOUT;
            frameError_d   = 1'b1;
            opcodeShadow_d = 8'h00;
            startShadow_d  = 16'h0000;
            endShadow_d    = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if ((rx_byte == OP_READ) || (rx_byte == OP_WRITE)) begin
                            opcodeShadow_d = rx_byte;
                            state_d        = ST_SA_HI;
                        end else begin
                            errCode_d    = ERR_OPCODE;
                            frameError_d = 1'b1;
                        end
                    end
                end
                ST_SA_HI: begin
                    if (accept) begin
                        startShadow_d[15:8] = rx_byte;
                        state_d             = ST_SA_LO;
                    end
                end
                ST_SA_LO: begin
                    if (accept) begin
                        startShadow_d[7:0] = rx_byte;
                        state_d            = ST_EA_HI;
                    end
                end
                ST_EA_HI: begin
                    if (accept) begin
                        endShadow_d[15:8] = rx_byte;
                        state_d           = ST_EA_LO;
                    end
                end
                ST_EA_LO: begin
                    if (accept) begin
                        endShadow_d[7:0] = rx_byte;
                        state_d          = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (startShadow_q > endShadow_q) begin
                        errCode_d    = ERR_RANGE;
                        frameError_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        command_d   = opcodeShadow_q;
                        startAddr_d = startShadow_q;
                        endAddr_d   = endShadow_q;
                        cmdValid_d  = 1'b1;
                        state_d     = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (cmdValid_q && cmd_ready) begin
                        cmdValid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    cmdValid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers. The reset clears any partial frame or
    // pending command at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            armed_q        <= 1'b1;
            timeoutCnt_q   <= '0;
            opcodeShadow_q <= 8'h00;
            startShadow_q  <= 16'h0000;
            endShadow_q    <= 16'h0000;
            command_q      <= 8'h00;
            startAddr_q    <= 16'h0000;
            endAddr_q      <= 16'h0000;
            cmdValid_q     <= 1'b0;
            rxAck_q        <= 1'b0;
            frameError_q   <= 1'b0;
            errCode_q      <= 2'd0;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            timeoutCnt_q   <= timeoutCnt_d;
            opcodeShadow_q <= opcodeShadow_d;
            startShadow_q  <= startShadow_d;
            endShadow_q    <= endShadow_d;
            command_q      <= command_d;
            startAddr_q    <= startAddr_d;
            endAddr_q      <= endAddr_d;
            cmdValid_q     <= cmdValid_d;
            rxAck_q        <= rxAck_d;
            frameError_q   <= frameError_d;
            errCode_q      <= errCode_d;
        end
    end

    assign rx_ack        = rxAck_q;
    assign command       = command_q;
    assign start_address = startAddr_q;
    assign end_address   = endAddr_q;
    assign cmd_valid     = cmdValid_q;
    assign frame_error   = frameError_q;
    assign err_code      = errCode_q;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Testbench for uart_command_decoder: directed frames from the test plan
// followed by randomized frames. Expected results come from a frame-level
// model that classifies each whole frame (bad opcode, inverted range, valid).

module tb_uart_command_decoder;

    localparam int unsigned TO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic        rx_ack;
    logic [7:0]  command;
    logic [15:0] start_address;
    logic [15:0] end_address;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        frame_error;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;
    int ackCount = 0;
    int errPulseCount = 0;

    logic        ackFrameError;
    logic [1:0]  ackErrCode;

    // Frame-level model of what the processor should currently see.
    logic [7:0]  expCmd;
    logic [15:0] expSa;
    logic [15:0] expEa;
    logic [1:0]  expErr;

    always #5 clk = ~clk;

    uart_command_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_byte       (rx_byte),
        .rx_done       (rx_done),
        .rx_ack        (rx_ack),
        .command       (command),
        .start_address (start_address),
        .end_address   (end_address),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .frame_error   (frame_error),
        .err_code      (err_code)
    );

    // Count rx_ack and frame_error pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_ack) ackCount++;
            if (frame_error) errPulseCount++;
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte, wait (bounded) for its rx_ack, then drop rx_done for
    // one cycle so the next byte can be accepted.
    task automatic applyStimulus(input logic [7:0] b);
        bit got;
        got = 1'b0;
        rx_byte = b;
        rx_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        ackFrameError = frame_error;
        ackErrCode    = err_code;
        rx_done = 1'b0;
        checkOutput("rxAckSeen", 32'(got), 32'd1);
        tick();
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_cmd"},   32'(command),       32'(expCmd));
        checkOutput({tag, "_start"}, 32'(start_address), 32'(expSa));
        checkOutput({tag, "_end"},   32'(end_address),   32'(expEa));
    endtask

    // Send one frame and check its outcome against the frame-level model.
    task automatic runFrame(input logic [7:0] op, input logic [15:0] sa, input logic [15:0] ea,
                            input int maxGap, input bit readyEarly, input int holdCycles);
        logic [7:0] bytes [5];
        int errBefore;
        bit stable;
        errBefore = errPulseCount;
        if (op != 8'h01 && op != 8'h02) begin
            applyStimulus(op);
            expErr = 2'd1;
            checkOutput("badOpPulse", 32'(ackFrameError), 32'd1);
            checkOutput("badOpCode", 32'(ackErrCode), 32'(expErr));
            checkOutput("badOpPulseCount", 32'(errPulseCount - errBefore), 32'd1);
            checkOutput("badOpNoValid", 32'(cmd_valid), 32'd0);
            return;
        end
        bytes[0] = op;
        bytes[1] = sa[15:8];
        bytes[2] = sa[7:0];
        bytes[3] = ea[15:8];
        bytes[4] = ea[7:0];
        if (readyEarly) cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (maxGap > 0) repeat ($urandom_range(0, maxGap)) tick();
            applyStimulus(bytes[i]);
        end
        if (sa > ea) begin
            expErr = 2'd3;
            checkOutput("rangeErrPulse", 32'(frame_error), 32'd1);
            checkOutput("rangeErrCode", 32'(err_code), 32'(expErr));
            checkOutput("rangeNoValid", 32'(cmd_valid), 32'd0);
            checkHeld("rangeHeld");
            tick();
            checkOutput("rangePulseCount", 32'(errPulseCount - errBefore), 32'd1);
            checkOutput("rangeNoValidLater", 32'(cmd_valid), 32'd0);
            cmd_ready = 1'b0;
        end else begin
            expCmd = op;
            expSa  = sa;
            expEa  = ea;
            checkOutput("validRise", 32'(cmd_valid), 32'd1);
            checkOutput("validNoErr", 32'(frame_error), 32'd0);
            checkOutput("validErrCodeKept", 32'(err_code), 32'(expErr));
            checkHeld("validTriple");
            if (!readyEarly) begin
                stable = 1'b1;
                repeat (holdCycles) begin
                    tick();
                    if (cmd_valid !== 1'b1 || command !== expCmd ||
                        start_address !== expSa || end_address !== expEa) stable = 1'b0;
                end
                checkOutput("holdStable", 32'(stable), 32'd1);
                cmd_ready = 1'b1;
            end
            tick();
            cmd_ready = 1'b0;
            checkOutput("transferDone", 32'(cmd_valid), 32'd0);
            checkHeld("afterTransfer");
        end
    endtask

    initial begin
        int ackBefore;
        int k;
        bit found;
        logic [7:0]  rop;
        logic [15:0] rsa;
        logic [15:0] rea;

        rst_n = 1'b0;
        rx_byte = 8'h00;
        rx_done = 1'b0;
        cmd_ready = 1'b0;
        expCmd = 8'h00;
        expSa = 16'h0000;
        expEa = 16'h0000;
        expErr = 2'd0;

        #2;
        checkOutput("resetValid", 32'(cmd_valid), 32'd0);
        checkOutput("resetAck", 32'(rx_ack), 32'd0);
        checkOutput("resetFrameErr", 32'(frame_error), 32'd0);
        checkOutput("resetErrCode", 32'(err_code), 32'd0);
        checkHeld("reset");

        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Read frame held for 100 cycles before the processor accepts it.
        runFrame(8'h01, 16'h0010, 16'h001F, 0, 1'b0, 100);

        // Bad opcode followed by a single-address write frame.
        runFrame(8'h7E, 16'h0000, 16'h0000, 0, 1'b0, 0);
        runFrame(8'h02, 16'h1234, 16'h1234, 0, 1'b0, 3);

        // Inverted range leaves the previous triple untouched.
        runFrame(8'h01, 16'h0020, 16'h0010, 0, 1'b0, 0);

        // Ready already high when cmd_valid rises.
        runFrame(8'h02, 16'h0000, 16'hFFFF, 2, 1'b1, 0);

        // Timeout: two bytes then silence.
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        k = 1;
        found = 1'b0;
        while (k < 200) begin
            tick();
            k++;
            if (frame_error === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        expErr = 2'd2;
        checkOutput("timeoutSeen", 32'(found), 32'd1);
        checkOutput("timeoutLatency", 32'(k), 32'(TO + 1));
        checkOutput("timeoutCode", 32'(err_code), 32'(expErr));
        checkOutput("timeoutNoValid", 32'(cmd_valid), 32'd0);
        tick();
        runFrame(8'h02, 16'h0100, 16'h0200, 1, 1'b0, 2);

        // Backpressure: a level-held byte is consumed only once.
        ackBefore = ackCount;
        rx_byte = 8'h01;
        rx_done = 1'b1;
        repeat (10) tick();
        rx_done = 1'b0;
        checkOutput("heldByteOneAck", 32'(ackCount - ackBefore), 32'd1);
        tick();
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        applyStimulus(8'h04);
        applyStimulus(8'h00);
        expCmd = 8'h01;
        expSa  = 16'h0300;
        expEa  = 16'h0400;
        checkOutput("bpValid", 32'(cmd_valid), 32'd1);
        checkHeld("bpTriple");
        ackBefore = ackCount;
        rx_byte = 8'h55;
        rx_done = 1'b1;
        repeat (8) tick();
        checkOutput("presentNoAck", 32'(ackCount - ackBefore), 32'd0);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checkOutput("bpTransfer", 32'(cmd_valid), 32'd0);
        repeat (3) tick();
        rx_done = 1'b0;
        expErr = 2'd1;
        checkOutput("ackAfterTransfer", 32'(ackCount - ackBefore), 32'd1);
        checkOutput("postTransferBadOp", 32'(err_code), 32'(expErr));
        tick();

        // Reset in the middle of a frame.
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        #3;
        rst_n = 1'b0;
        #1;
        expCmd = 8'h00;
        expSa  = 16'h0000;
        expEa  = 16'h0000;
        expErr = 2'd0;
        checkOutput("midResetValid", 32'(cmd_valid), 32'd0);
        checkOutput("midResetErrCode", 32'(err_code), 32'(expErr));
        checkOutput("midResetAck", 32'(rx_ack), 32'd0);
        checkHeld("midReset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        runFrame(8'h01, 16'h0AAA, 16'h0BBB, 1, 1'b0, 2);

        // Randomized frames checked against the frame-level model.
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0:       rop = 8'h01;
                1:       rop = 8'h02;
                2:       rop = 8'($urandom_range(0, 255));
                default: rop = 8'h02;
            endcase
            rsa = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) rea = rsa;
            else rea = 16'($urandom_range(0, 65535));
            runFrame(rop, rsa, rea, 4, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
